instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch front end between the program counter and the IF/ID barrier. It replaces the combinational instruction-address/success path with a request/ready handshake to the memory handler.
- Holds the fetch PC and keeps exactly one instruction request in flight.
- Buffers up to two returned instructions (output register plus skid register) while the pipeline is stalled.
- Handles branch redirects, discarding any wrong-path response that is still in flight.

Parameters:
- XLEN, 32: data and address width.
- RESET_PC, 32'h00000000: first fetch address after reset.
- NOP_INSTR, 32'h00000013: value driven on instr while it is invalid (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode-stage stall; the held instruction is not consumed in this cycle.
- redirect  input  1  taken branch or jump; flush and refetch from redirectTarget.
- redirectTarget  input  XLEN  new fetch address; bits [1:0] are forced to 0.
- memReq  output  1  instruction request strobe, one cycle per request.
- memAddr  output  XLEN  request address; stable from the memReq cycle until memReady.
- memReady  input  1  one-cycle response strobe from the memory handler.
- memData  input  XLEN  instruction word, valid when memReady=1.
- instrValid  output  1  instr and instrPc hold a valid fetched instruction.
- instr  output  XLEN  instruction word to the IF/ID barrier.
- instrPc  output  XLEN  address of instr.
- fetchPc  output  XLEN  address of the current or next request (debug).

Behaviour:
- Reset: fetchPc=RESET_PC, instrValid=0, instr=NOP_INSTR, instrPc=0, skid register empty, state=REQ. memReq is asserted in the first cycle after reset deasserts. Reset mid-request abandons the request; the memory handler is reset by the same signal.
- Transfer: a transfer happens in any cycle with instrValid=1, stall=0 and redirect=0. If there is no refill in that cycle, the next cycle has instrValid=0, instr=NOP_INSTR.
- Memory protocol: memReady arrives at least 1 cycle after the memReq cycle. At most one request is outstanding. memReady in state REQ or FULL is ignored.
- Output registers: instr, instrValid and instrPc are registered. memAddr is equal to fetchPc. memReq is 1 exactly when the state is REQ.
- State REQ: memReq=1 for one cycle, then go to WAIT.
- State WAIT, memReady=0: stay in WAIT.
- State WAIT, memReady=1, output empty or transferring: load memData and fetchPc into the output; fetchPc+=4; go to REQ. Fetch-to-instrValid latency equals memory latency plus 1 cycle.
- State WAIT, memReady=1, output full and not transferring: load memData and fetchPc into the skid register; fetchPc+=4; go to FULL.
- State FULL: no requests are issued. On a transfer, the skid entry moves to the output registers in the same edge, the skid empties, and the state goes to REQ.
- Invariant: the skid register is empty in REQ, WAIT and DROP.
- State DROP: wait for memReady and discard memData, then go to REQ. stall has no effect in DROP.
- Redirect (highest priority, overrides stall and any same-cycle memReady):
  - Next cycle: instrValid=0, instr=NOP_INSTR, skid emptied, fetchPc={redirectTarget[XLEN-1:2],2'b00}.
  - State WAIT with memReady=0 at the redirect goes to DROP.
  - State REQ goes to DROP, because the request has been issued.
  - WAIT with memReady=1, FULL, or DROP goes to REQ; in DROP, if the stale response has not arrived yet, go to DROP instead.
- Redirect while in DROP: update fetchPc; stay in DROP unless memReady=1 in the same cycle, in which case go to REQ.
- Wrap-around: fetchPc+4 wraps modulo 2^XLEN with no flag.

Test Plan:
- Reset, memory with 2-cycle latency returning addr+100 as data, stall=0 → memReq at cycle 1 with memAddr=0; instrValid=1, instr=100, instrPc=0 at cycle 4; next memAddr=4.
- Hold stall=1 for 10 cycles starting with instr at PC 0 valid → output holds PC 0 and skid holds PC 4; no memReq while in FULL; on release, PC 0 then PC 4 are delivered on consecutive cycles, and memReq for 8 appears one cycle after the PC 0 transfer.
- Redirect to 0x40 one cycle after the request for 0x8 (state WAIT), response for 0x8 arriving 2 cycles later → that response is dropped; next memAddr=0x40; the first valid instrPc after the redirect is 0x40, with no instruction from 0x8.
- redirect and memReady in the same cycle, target 0x103 → data discarded, next memAddr=0x100, no DROP state visited.
- RESET_PC=32'hFFFFFFFC → second request address is 0x00000000.
- Assert reset while in WAIT → instrValid=0, instr=0x00000013 next cycle; fresh memReq at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch front end: PC, single in-flight request, output+skid buffer, redirect/drop
module instruction_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectTarget,
    output logic            memReq,
    output logic [XLEN-1:0] memAddr,
    input  logic            memReady,
    input  logic [XLEN-1:0] memData,
    output logic            instrValid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instrPc,
    output logic [XLEN-1:0] fetchPc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic            transfer;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] pc_plus4;
    logic            unused_target_bits;

    assign transfer           = out_valid_q && !stall && !redirect;
    assign target_aligned     = {redirectTarget[XLEN-1:2], 2'b00};
    assign pc_plus4           = pc_q + XLEN'(4);
    assign unused_target_bits = ^redirectTarget[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_REQ;
            pc_q         <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state        <= state_next;
            pc_q         <= pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        state_next   = state;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        // A consumed instruction leaves a bubble unless something refills it below.
        if (transfer) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
        end

        if (redirect) begin
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            skid_valid_d = 1'b0;
            pc_d         = target_aligned;
            case (state)
                S_REQ:   state_next = S_DROP;
                S_WAIT:  state_next = memReady ? S_REQ : S_DROP;
                S_FULL:  state_next = S_REQ;
                S_DROP:  state_next = memReady ? S_REQ : S_DROP;
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: state_next = S_WAIT;
                S_WAIT: begin
                    if (memReady) begin
                        pc_d = pc_plus4;
                        if (!out_valid_q || transfer) begin
                            out_valid_d = 1'b1;
                            out_instr_d = memData;
                            out_pc_d    = pc_q;
                            state_next  = S_REQ;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = memData;
                            skid_pc_d    = pc_q;
                            state_next   = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    // Output is always valid here, so a transfer drains the skid entry.
                    if (transfer) begin
                        out_valid_d  = 1'b1;
                        out_instr_d  = skid_instr_q;
                        out_pc_d     = skid_pc_q;
                        skid_valid_d = 1'b0;
                        state_next   = S_REQ;
                    end
                end
                S_DROP: begin
                    if (memReady) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    assign memReq     = (state == S_REQ);
    assign memAddr    = pc_q;
    assign fetchPc    = pc_q;
    assign instrValid = out_valid_q;
    assign instr      = out_instr_q;
    assign instrPc    = out_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] fetch_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ready = 1'b0;
    logic [31:0] w_data = '0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic [31:0] w_fpc;
    logic        w_zero = 1'b0;
    logic [31:0] w_target = '0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirectTarget(redirect_target), .memReq(mem_req), .memAddr(mem_addr),
        .memReady(mem_ready), .memData(mem_data), .instrValid(instr_valid),
        .instr(instr), .instrPc(instr_pc), .fetchPc(fetch_pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(w_zero), .redirect(w_zero),
        .redirectTarget(w_target), .memReq(w_req), .memAddr(w_addr),
        .memReady(w_ready), .memData(w_data), .instrValid(w_valid),
        .instr(w_instr), .instrPc(w_ipc), .fetchPc(w_fpc)
    );

    int checks = 0;
    int errors = 0;
    int transfers = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_next;

    bit          fixed_lat = 1'b1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          countdown = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Program order after a (re)start: sequential words, data = address + 100.
    function automatic void top_up();
        while (exp_q.size() < 16) begin
            exp_t e;
            e.pc   = model_next;
            e.data = model_next + 32'd100;
            exp_q.push_back(e);
            model_next = model_next + 32'd4;
        end
    endfunction

    function automatic void restart(input logic [31:0] start);
        exp_q.delete();
        model_next = start;
        top_up();
    endfunction

    always @(negedge clk) begin
        mem_ready = 1'b0;
        mem_data  = 32'hDEADBEEF;
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (countdown <= 1) begin
                    mem_ready = 1'b1;
                    mem_data  = pend_addr + 32'd100;
                    pend      = 1'b0;
                end else begin
                    countdown--;
                end
            end
            if (mem_req) begin
                check("one_outstanding", 32'(pend), 32'd0);
                pend      = 1'b1;
                pend_addr = mem_addr;
                countdown = fixed_lat ? 2 : int'($urandom_range(1, 4));
            end
        end
    end

    int w_count = 0;
    bit w_pend = 1'b0;
    always @(negedge clk) begin
        w_ready = 1'b0;
        if (reset) begin
            w_pend  = 1'b0;
            w_count = 0;
        end else begin
            if (w_pend) begin
                w_ready = 1'b1;
                w_pend  = 1'b0;
            end
            if (w_req) begin
                w_pend = 1'b1;
                w_count++;
                if (w_count == 1) check("wrap_first_addr", w_addr, 32'hFFFFFFFC);
                if (w_count == 2) check("wrap_second_addr", w_addr, 32'h00000000);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                check("memaddr_eq_fetchpc", mem_addr, fetch_pc);
                if (!instr_valid) begin
                    check("nop_when_invalid", instr, NOP);
                end else if (!stall && !redirect) begin
                    transfers++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty actual=no_entry required=entry pc=%h", instr_pc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_pc", instr_pc, e.pc);
                        check("sb_instr", instr, e.data);
                        top_up();
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int mreq_cnt;
        restart(32'h0);
        reset = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        check("rst_memreq", 32'(mem_req), 32'd1);
        check("rst_memaddr", mem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP);
        step(); step(); step();
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_instr", instr, 32'd100);
        check("first_pc", instr_pc, 32'h0);
        check("second_addr", mem_addr, 32'h4);

        stall    = 1'b1;
        mreq_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            mreq_cnt += int'(mem_req);
            check("stall_hold_valid", 32'(instr_valid), 32'd1);
            check("stall_hold_pc", instr_pc, 32'h0);
        end
        check("stall_memreq_count", 32'(mreq_cnt), 32'd1);
        step();
        stall = 1'b0;
        check("release_pc0", instr_pc, 32'h0);
        step();
        check("release_pc4_valid", 32'(instr_valid), 32'd1);
        check("release_pc4", instr_pc, 32'h4);
        check("release_memreq", 32'(mem_req), 32'd1);
        check("release_memaddr", mem_addr, 32'h8);

        step();
        redirect        = 1'b1;
        redirect_target = 32'h40;
        restart(32'h40);
        step();
        redirect = 1'b0;
        check("drop_no_memreq", 32'(mem_req), 32'd0);
        step();
        check("redir_memreq", 32'(mem_req), 32'd1);
        check("redir_memaddr", mem_addr, 32'h40);

        step(); step();
        redirect        = 1'b1;
        redirect_target = 32'h103;
        restart(32'h100);
        step();
        redirect = 1'b0;
        check("samecyc_memreq", 32'(mem_req), 32'd1);
        check("samecyc_memaddr", mem_addr, 32'h100);
        check("samecyc_valid", 32'(instr_valid), 32'd0);

        step();
        reset = 1'b1;
        restart(32'h0);
        step();
        check("midreset_valid", 32'(instr_valid), 32'd0);
        check("midreset_instr", instr, NOP);
        reset = 1'b0;
        check("midreset_memreq", 32'(mem_req), 32'd1);
        check("midreset_memaddr", mem_addr, 32'h0);

        fixed_lat = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            stall    = ($urandom_range(0, 99) < 30);
            redirect = 1'b0;
            reset    = 1'b0;
            if ($urandom_range(0, 99) < 4) begin
                redirect        = 1'b1;
                redirect_target = $urandom;
                restart({redirect_target[31:2], 2'b00});
            end
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                restart(32'h0);
            end
        end
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        reset    = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("progress", 32'(transfers > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
